divider_32: RTL and testbench
=============================

Name: divider_32

Overview:
- Iterative 32-bit integer divider for the RISC-V M-extension DIV/DIVU/REM/REMU instructions.
- Sits beside multiplier_32 in core/muldiv. Where the multiplier is a fixed-latency pipeline, this block is the inverse operation: a multi-cycle, non-pipelined unit with a start/busy/done handshake.
- Radix-2 restoring algorithm on operand magnitudes, followed by a sign/special-case fix-up cycle.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported, and the iteration count equals XLEN.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled with start.
- D_inA  input  32  dividend; sampled with start.
- D_inB  input  32  divisor; sampled with start.
- busy  output  1  operation in progress; start is ignored while high.
- done  output  1  one-cycle pulse: R is valid.
- R  output  32  quotient (DIV/DIVU) or remainder (REM/REMU); held until the next accepted start.

Behaviour:
- Reset is synchronous and active-high: reset=1 at a rising edge forces state=IDLE, busy=0, done=0, R=0, and clears all internal registers. Reset mid-operation aborts with no done pulse.
- State machine: IDLE -> CALC -> FIX -> IDLE.
- IDLE:
  - busy=0.
  - If start=1 at an edge: latch op; latch |D_inA| and |D_inB| (absolute value only for signed ops, using two's-complement negate, so |0x80000000| = 0x80000000 unsigned); record sign_q = signA XOR signB and sign_r = signA (signed ops only); clear the 33-bit partial remainder and the 32-bit quotient shift register; set count=0; go to CALC.
- CALC:
  - busy=1.
  - Each cycle: shift {rem, quo} left 1 with the next dividend bit entering; trial-subtract the divisor magnitude. If the result is non-negative, keep it and set quo[0]=1; otherwise restore and set quo[0]=0.
  - count increments; after the 32nd iteration (count==31), go to FIX.
- FIX:
  - busy=1.
  - Apply signs: quotient negated if sign_q, remainder negated if sign_r.
  - Apply special cases, overriding the computed value:
    - divisor==0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give the original dividend.
    - DIV of 0x80000000 by 0xFFFFFFFF gives 0x80000000; REM of the same gives 0.
  - Load R with the selected value, assert done for the next cycle, go to IDLE.
- Latency:
  - start high in cycle 0 -> busy high cycles 1..33 -> done=1 and R valid in cycle 34.
  - Fixed at 34 cycles regardless of operand values (unless the optional feature is enabled).
- Handshake:
  - done is high for exactly one cycle, and busy=0 in that cycle.
  - start asserted in the done cycle is accepted (back-to-back operation); R keeps its value until the FIX of that new operation.
  - start while busy=1 is ignored; no queueing.
  - Operand inputs need only be stable in the start cycle.
- Result signs follow RISC-V: the quotient truncates toward zero, and the remainder has the sign of the dividend.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- When defined: in IDLE, on an accepted start, a special case is detected from the raw operands and the block jumps directly to FIX, giving done in cycle 2 with identical result values. The special cases are:
  - divisor==0;
  - signed overflow;
  - unsigned |dividend| < |divisor|, where quotient=0 and remainder=dividend with its original sign.
- When undefined: all operations take the fixed 34-cycle path.
- Results must be bit-identical with and without the macro; only latency differs.

Test Plan:
- DIVU 100/7, then REMU 100/7 -> R=14 (0x0000000E), then R=2; done exactly in cycle 34 after start; busy high cycles 1..33.
- DIV 0xFFFFFFF9 (-7) / 2 -> R=0xFFFFFFFD (-3); REM same operands -> R=0xFFFFFFFF (-1); REM 7 / 0xFFFFFFFE -> R=1.
- Divide by zero: DIV 0x12345678/0 -> 0xFFFFFFFF; REMU 0x12345678/0 -> 0x12345678. With DIV_EARLY_OUT_EN, done arrives in cycle 2 instead of 34.
- Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0; DIVU 0x80000000/0xFFFFFFFF -> 0.
- Handshake:
  - Pulse start with new operands at cycle 10 of a busy operation -> ignored, and the first result is unaffected.
  - Assert start in the done cycle -> second result appears 34 cycles later, and R holds the first result until then.
- Reset: assert reset at cycle 15 of an operation -> next edge gives busy=0, done=0, R=0, and no done pulse follows. A new start afterwards completes normally.

Source files
------------

// File: rtl/divider_32.sv
// Iterative radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU, 34-cycle start/busy/done handshake.
// Optional macro DIV_EARLY_OUT_EN: special-case operands skip CALC and finish in 2 cycles.
module divider_32 #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] D_inA,
    input  logic [XLEN-1:0] D_inB,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] R
);

    // state  | meaning
    // S_IDLE | waiting for start; done pulses here for one cycle after FIX
    // S_CALC | one restoring iteration per cycle, 32 cycles
    // S_FIX  | apply signs and special cases, load R
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]      state;
    logic [1:0]      op_q;
    logic [XLEN-1:0] a_raw;
    logic [XLEN-1:0] b_raw;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] quo;
    logic [4:0]      count;
    logic            sign_q;
    logic            sign_r;
    logic            early_small;

    logic            in_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] q_signed;
    logic [XLEN-1:0] r_signed;
    logic            div_zero;
    logic            ovf;
    logic [XLEN-1:0] fix_val;

    assign busy = (state != S_IDLE);

    assign in_signed = ~op[0];
    assign a_neg     = in_signed & D_inA[XLEN-1];
    assign b_neg     = in_signed & D_inB[XLEN-1];
    assign abs_a     = a_neg ? (~D_inA + 1'b1) : D_inA;
    assign abs_b     = b_neg ? (~D_inB + 1'b1) : D_inB;

    // The partial remainder never exceeds the divisor, so 32 stored bits plus the
    // incoming dividend bit form the full 33-bit working value.
    assign shifted = {rem, mag_a[5'd31 - count]};
    assign trial   = shifted - {1'b0, mag_b};

    assign q_signed = sign_q ? (~quo + 1'b1) : quo;
    assign r_signed = sign_r ? (~rem + 1'b1) : rem;
    assign div_zero = (b_raw == '0);
    assign ovf      = ~op_q[0] & (a_raw == 32'h8000_0000) & (b_raw == 32'hFFFF_FFFF);

    always_comb begin
        fix_val = op_q[1] ? r_signed : q_signed;
        if (div_zero) begin
            fix_val = op_q[1] ? a_raw : 32'hFFFF_FFFF;
        end else if (ovf) begin
            fix_val = op_q[1] ? 32'h0000_0000 : 32'h8000_0000;
        end else if (early_small) begin
            fix_val = op_q[1] ? a_raw : 32'h0000_0000;
        end
    end

`ifdef DIV_EARLY_OUT_EN
    logic start_special;
    logic start_small;
    assign start_small   = (abs_a < abs_b);
    assign start_special = (D_inB == '0) | start_small |
                           (in_signed & (D_inA == 32'h8000_0000) & (D_inB == 32'hFFFF_FFFF));
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            op_q        <= '0;
            a_raw       <= '0;
            b_raw       <= '0;
            mag_a       <= '0;
            mag_b       <= '0;
            rem         <= '0;
            quo         <= '0;
            count       <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            early_small <= 1'b0;
            done        <= 1'b0;
            R           <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q        <= op;
                        a_raw       <= D_inA;
                        b_raw       <= D_inB;
                        mag_a       <= abs_a;
                        mag_b       <= abs_b;
                        sign_q      <= a_neg ^ b_neg;
                        sign_r      <= a_neg;
                        rem         <= '0;
                        quo         <= '0;
                        count       <= '0;
`ifdef DIV_EARLY_OUT_EN
                        early_small <= start_small;
                        state       <= start_special ? S_FIX : S_CALC;
`else
                        early_small <= 1'b0;
                        state       <= S_CALC;
`endif
                    end
                end
                S_CALC: begin
                    rem   <= trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
                    quo   <= {quo[XLEN-2:0], ~trial[XLEN]};
                    count <= count + 5'd1;
                    if (count == 5'd31) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    R     <= fix_val;
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_32.sv
// Directed bench for divider_32: vector table plus handshake, back-to-back and reset sequences.
module tb_divider_32;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] D_inA;
    logic [31:0] D_inB;
    logic        busy;
    logic        done;
    logic [31:0] R;

    int n_pass = 0;
    int n_total = 0;

    divider_32 dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .D_inA (D_inA),
        .D_inB (D_inB),
        .busy  (busy),
        .done  (done),
        .R     (R)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_r;
        bit          early;
    } vec_t;

    localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    endtask

    // Called at posedge+1; returns at posedge+1 of cycle 1 of the operation.
    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        D_inA = a;
        D_inB = b;
        @(posedge clk); #1;
        start = 1'b0;
        op    = 2'($urandom);
        D_inA = $urandom;
        D_inB = $urandom;
    endtask

    task automatic wait_done(input int c0, output int lat, output int busy_cycles);
        lat = c0;
        busy_cycles = 0;
        while (done !== 1'b1 && lat < 80) begin
            if (busy === 1'b1) busy_cycles++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    function automatic int exp_lat(input bit early);
`ifdef DIV_EARLY_OUT_EN
        return early ? 2 : 34;
`else
        return 34;
`endif
    endfunction

    vec_t vecs[16];
    int   lat;
    int   bcnt;
    int   r_bad;
    int   done_seen;

    initial begin
        vecs[0]  = '{OP_DIVU, 32'd100,        32'd7,          32'h0000_000E, 1'b0};
        vecs[1]  = '{OP_REMU, 32'd100,        32'd7,          32'h0000_0002, 1'b0};
        vecs[2]  = '{OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD, 1'b0};
        vecs[3]  = '{OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 1'b0};
        vecs[4]  = '{OP_REM,  32'd7,          32'hFFFF_FFFE,  32'h0000_0001, 1'b0};
        vecs[5]  = '{OP_DIV,  32'h1234_5678,  32'd0,          32'hFFFF_FFFF, 1'b1};
        vecs[6]  = '{OP_REMU, 32'h1234_5678,  32'd0,          32'h1234_5678, 1'b1};
        vecs[7]  = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 1'b1};
        vecs[8]  = '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 1'b1};
        vecs[9]  = '{OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 1'b1};
        vecs[10] = '{OP_DIV,  32'd5,          32'hFFFF_FFF6,  32'h0000_0000, 1'b1};
        vecs[11] = '{OP_REM,  32'hFFFF_FFFB,  32'd10,         32'hFFFF_FFFB, 1'b1};
        vecs[12] = '{OP_DIV,  32'h8000_0000,  32'd2,          32'hC000_0000, 1'b0};
        vecs[13] = '{OP_REMU, 32'hFFFF_FFFF,  32'h0000_0010,  32'h0000_000F, 1'b0};
        vecs[14] = '{OP_DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'h0000_000E, 1'b0};
        vecs[15] = '{OP_REM,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE, 1'b0};

        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        D_inA = '0;
        D_inB = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_R", R, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            launch(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(1, lat, bcnt);
            check($sformatf("vec%0d_R", i), R, vecs[i].exp_r);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(exp_lat(vecs[i].early)));
            check($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), 32'(exp_lat(vecs[i].early) - 1));
            check($sformatf("vec%0d_busy_at_done", i), 32'(busy), 32'd0);
            @(posedge clk); #1;
            check($sformatf("vec%0d_done_pulse", i), 32'(done), 32'd0);
        end

        // start pulsed mid-operation must be ignored
        launch(OP_DIVU, 32'd100, 32'd7);
        repeat (9) begin @(posedge clk); #1; end
        start = 1'b1; op = OP_REMU; D_inA = 32'd1000; D_inB = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(11, lat, bcnt);
        check("ignored_start_R", R, 32'h0000_000E);
        check("ignored_start_latency", 32'(lat), 32'd34);
        @(posedge clk); #1;
        check("ignored_start_no_second_done", 32'(done), 32'd0);
        repeat (40) begin
            if (done === 1'b1) done_seen++;
            @(posedge clk); #1;
        end
        check("ignored_start_no_queued_op", 32'(done_seen), 32'd0);

        // start in the done cycle is accepted; R holds the first result meanwhile
        launch(OP_DIVU, 32'd100, 32'd7);
        wait_done(1, lat, bcnt);
        check("b2b_first_R", R, 32'h0000_000E);
        launch(OP_REMU, 32'd1000, 32'd3);
        lat = 1;
        r_bad = 0;
        while (done !== 1'b1 && lat < 80) begin
            if (R !== 32'h0000_000E) r_bad++;
            @(posedge clk); #1;
            lat++;
        end
        check("b2b_R_hold", 32'(r_bad), 32'd0);
        check("b2b_second_R", R, 32'h0000_0001);
        check("b2b_second_latency", 32'(lat), 32'd34);
        @(posedge clk); #1;

        // reset mid-operation aborts silently
        launch(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        repeat (14) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_R", R, 32'd0);
        done_seen = 0;
        repeat (40) begin
            if (done === 1'b1) done_seen++;
            @(posedge clk); #1;
        end
        check("abort_no_done", 32'(done_seen), 32'd0);
        launch(OP_DIVU, 32'd100, 32'd7);
        wait_done(1, lat, bcnt);
        check("after_abort_R", R, 32'h0000_000E);
        check("after_abort_latency", 32'(lat), 32'd34);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
